systolic_matmul_engine: RTL

//  Parametrised MxN output-stationary systolic matrix-multiply engine computing C = A(MxK) * B(KxN), K runtime-variable.

---
 rtl/systolic_matmul_engine.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/systolic_matmul_engine.sv
`default_nettype none
// -----------------------------------------------------------------------------
// systolic_matmul_engine - output-stationary MxN systolic C = A*B, K runtime.  Rev 1.0
// -----------------------------------------------------------------------------
module systolic_matmul_engine #(
    parameter int M      = 16,
    parameter int N      = 16,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    output logic                                  busy,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic                                  in_last,
    input  logic [M*DATA_W-1:0]                   in_row,
    input  logic [N*DATA_W-1:0]                   in_col,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [((M > 1) ? $clog2(M) : 1)-1:0]  out_row,
    output logic [N*ACC_W-1:0]                    out_data,
    output logic                                  done
);

    localparam int ROW_W = (M > 1) ? $clog2(M) : 1;
    localparam int CNT_W = $clog2(M + N) + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             done_q, done_d;

    logic fire;
    logic acc_clr;
    logic acc_en;

    logic signed [DATA_W-1:0] a_edge [M];
    logic signed [DATA_W-1:0] b_edge [N];
    logic signed [DATA_W-1:0] a_in   [M][N];
    logic signed [DATA_W-1:0] b_in   [M][N];
    logic signed [ACC_W-1:0]  prod   [M][N];
    logic signed [DATA_W-1:0] a_q    [M][N-1];
    logic signed [DATA_W-1:0] b_q    [M-1][N];
    logic signed [ACC_W-1:0]  acc_q  [M][N];

    assign fire    = in_valid && (state_q == S_LOAD);
    assign acc_clr = (state_q == S_IDLE) && start;
    assign acc_en  = (state_q == S_LOAD) || (state_q == S_FLUSH);

    assign busy      = (state_q != S_IDLE);
    assign in_ready  = (state_q == S_LOAD);
    assign out_valid = (state_q == S_DRAIN);
    assign out_row   = row_q;
    assign done      = done_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    row_d   = '0;
                    cnt_d   = '0;
                end
            end
            S_LOAD: begin
                if (in_valid && in_last) begin
                    state_d = S_FLUSH;
                    cnt_d   = '0;
                end
            end
            S_FLUSH: begin
                // M+N-1 zero cycles: the last product lands in the corner PE on the final one
                if (cnt_q == CNT_W'(M + N - 2)) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DRAIN: begin
                if (out_ready) begin
                    if (row_q == ROW_W'(M - 1)) begin
                        state_d = S_IDLE;
                        row_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            row_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            done_q  <= done_d;
        end
    end

    // Row i sees i+1 register stages (input register plus i skew stages)
    for (genvar i = 0; i < M; i++) begin : g_row_skew
        logic signed [DATA_W-1:0] sk_q [0:i];
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                for (int d = 0; d <= i; d++) sk_q[d] <= '0;
            end else begin
                sk_q[0] <= fire ? in_row[i*DATA_W +: DATA_W] : '0;
                for (int d = 1; d <= i; d++) sk_q[d] <= sk_q[d-1];
            end
        end
        assign a_edge[i] = sk_q[i];
    end

    for (genvar j = 0; j < N; j++) begin : g_col_skew
        logic signed [DATA_W-1:0] sk_q [0:j];
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                for (int d = 0; d <= j; d++) sk_q[d] <= '0;
            end else begin
                sk_q[0] <= fire ? in_col[j*DATA_W +: DATA_W] : '0;
                for (int d = 1; d <= j; d++) sk_q[d] <= sk_q[d-1];
            end
        end
        assign b_edge[j] = sk_q[j];
    end

    for (genvar i = 0; i < M; i++) begin : g_pe_row
        for (genvar j = 0; j < N; j++) begin : g_pe_col
            if (j == 0) begin : g_a_edge
                assign a_in[i][j] = a_edge[i];
            end else begin : g_a_int
                assign a_in[i][j] = a_q[i][j-1];
            end
            if (i == 0) begin : g_b_edge
                assign b_in[i][j] = b_edge[j];
            end else begin : g_b_int
                assign b_in[i][j] = b_q[i-1][j];
            end
            // Operands sign-extended first, so the low ACC_W bits equal the wrapped product
            assign prod[i][j] = ACC_W'(a_in[i][j]) * ACC_W'(b_in[i][j]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < M; i++)
                for (int j = 0; j < N - 1; j++) a_q[i][j] <= '0;
            for (int i = 0; i < M - 1; i++)
                for (int j = 0; j < N; j++) b_q[i][j] <= '0;
            for (int i = 0; i < M; i++)
                for (int j = 0; j < N; j++) acc_q[i][j] <= '0;
        end else begin
            for (int i = 0; i < M; i++)
                for (int j = 0; j < N - 1; j++) a_q[i][j] <= a_in[i][j];
            for (int i = 0; i < M - 1; i++)
                for (int j = 0; j < N; j++) b_q[i][j] <= b_in[i][j];
            for (int i = 0; i < M; i++) begin
                for (int j = 0; j < N; j++) begin
                    if (acc_clr) begin
                        acc_q[i][j] <= '0;
                    end else if (acc_en) begin
                        acc_q[i][j] <= acc_q[i][j] + prod[i][j];
                    end
                end
            end
        end
    end

    always_comb begin
        out_data = '0;
        for (int j = 0; j < N; j++) out_data[j*ACC_W +: ACC_W] = acc_q[row_q][j];
    end

endmodule
`default_nettype wire
